// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit type, digit limits and a validity helper
// used by the counter and its per-digit slice.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic logic bcd_valid(input bcd_digit_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the cascaded counter: load, increment or decrement,
// with carry/borrow outputs that ripple into the next more significant digit.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  input  logic       load,
  input  bcd_digit_t load_digit,
  output bcd_digit_t digit,
  output logic       carry_out,
  output logic       borrow_out
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit <= BCD_MIN;
    end else if (load) begin
      digit <= load_digit;
    end else if (inc) begin
      digit <= (digit == BCD_MAX) ? BCD_MIN : digit + 4'd1;
    end else if (dec) begin
      digit <= (digit == BCD_MIN) ? BCD_MAX : digit - 4'd1;
    end
  end

  assign carry_out  = inc & (digit == BCD_MAX);
  assign borrow_out = dec & (digit == BCD_MIN);

endmodule

// File: rtl/bcd_updown_counter.sv
// Cascaded BCD up/down counter with wrap or saturate ends and terminal count.
// Define BCD_LOAD_EN to enable the checked parallel load and the ERR pulse.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int WRAP   = 1
) (
  input  logic                  CLK_in,
  input  logic                  RESET,
  input  logic                  EN,
  input  logic                  UP,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   LOAD_VAL,
  output logic [4*DIGITS-1:0]   BCD_out,
  output logic                  TC,
  output logic                  ERR
);

  localparam bit SATURATE = (WRAP == 0);

  logic [DIGITS:0]     inc_c;
  logic [DIGITS:0]     dec_c;
  logic [4*DIGITS-1:0] load_word;
  logic                load_ok;
  logic                count_en;
  logic                all_nine;
  logic                all_zero;
  logic                unused_chain;

  always_comb begin
    all_nine = 1'b1;
    all_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (BCD_out[4*i +: 4] != BCD_MAX) all_nine = 1'b0;
      if (BCD_out[4*i +: 4] != BCD_MIN) all_zero = 1'b0;
    end
  end

  // In saturate mode the least significant digit is simply never stepped past an end.
  assign inc_c[0] = count_en &  UP & ~(SATURATE & all_nine);
  assign dec_c[0] = count_en & ~UP & ~(SATURATE & all_zero);

  assign TC = EN & ((UP & all_nine) | (~UP & all_zero));

`ifdef BCD_LOAD_EN
  logic load_valid;

  always_comb begin
    load_valid = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bcd_valid(LOAD_VAL[4*i +: 4])) load_valid = 1'b0;
    end
  end

  // Any load strobe, accepted or rejected, blocks counting on that edge.
  assign load_ok   = LOAD & load_valid;
  assign count_en  = EN & ~LOAD;
  assign load_word = LOAD_VAL;

  always_ff @(posedge CLK_in or posedge RESET) begin
    if (RESET) begin
      ERR <= 1'b0;
    end else begin
      ERR <= LOAD & ~load_valid;
    end
  end

  assign unused_chain = ^{inc_c[DIGITS], dec_c[DIGITS]};
`else
  assign load_ok   = 1'b0;
  assign count_en  = EN;
  assign load_word = '0;
  assign ERR       = 1'b0;

  assign unused_chain = ^{inc_c[DIGITS], dec_c[DIGITS], LOAD, LOAD_VAL};
`endif

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk        (CLK_in),
      .rst        (RESET),
      .inc        (inc_c[i]),
      .dec        (dec_c[i]),
      .load       (load_ok),
      .load_digit (load_word[4*i +: 4]),
      .digit      (BCD_out[4*i +: 4]),
      .carry_out  (inc_c[i+1]),
      .borrow_out (dec_c[i+1])
    );
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: 2-digit wrap, 2-digit saturate and 4-digit wrap
// instances share stimulus and are checked every cycle against an integer model.
module tb_bcd_updown_counter;

`ifdef BCD_LOAD_EN
  localparam bit LOAD_ON = 1'b1;
`else
  localparam bit LOAD_ON = 1'b0;
`endif

  logic        CLK_in;
  logic        RESET;
  logic        EN;
  logic        UP;
  logic        LOAD;
  logic [15:0] LOAD_VAL;

  logic [7:0]  bcd2, bcds;
  logic [15:0] bcd4;
  logic        tc2, tcs, tc4;
  logic        err2, errs, err4;

  int total = 0;
  int bad   = 0;

  int   m2 = 0, ms = 0, m4 = 0;
  logic e2 = 1'b0, es = 1'b0, e4 = 1'b0;

  bcd_updown_counter #(.DIGITS(2), .WRAP(1)) dut2 (
    .CLK_in(CLK_in), .RESET(RESET), .EN(EN), .UP(UP), .LOAD(LOAD),
    .LOAD_VAL(LOAD_VAL[7:0]), .BCD_out(bcd2), .TC(tc2), .ERR(err2)
  );

  bcd_updown_counter #(.DIGITS(2), .WRAP(0)) duts (
    .CLK_in(CLK_in), .RESET(RESET), .EN(EN), .UP(UP), .LOAD(LOAD),
    .LOAD_VAL(LOAD_VAL[7:0]), .BCD_out(bcds), .TC(tcs), .ERR(errs)
  );

  bcd_updown_counter #(.DIGITS(4), .WRAP(1)) dut4 (
    .CLK_in(CLK_in), .RESET(RESET), .EN(EN), .UP(UP), .LOAD(LOAD),
    .LOAD_VAL(LOAD_VAL), .BCD_out(bcd4), .TC(tc4), .ERR(err4)
  );

  initial CLK_in = 1'b0;
  always #5 CLK_in = ~CLK_in;

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] toBcd(input int v);
    logic [15:0] r = '0;
    int x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit validBcd(input logic [15:0] x, input int digits);
    bit ok = 1'b1;
    for (int i = 0; i < digits; i++) if (x[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  function automatic int fromBcd(input logic [15:0] x, input int digits);
    int r = 0;
    for (int i = digits - 1; i >= 0; i--) r = r * 10 + int'(x[4*i +: 4]);
    return r;
  endfunction

  function automatic int nextCount(input int v, input int digits, input bit wrap,
                                   input logic en, input logic up, input logic ld,
                                   input logic [15:0] lv);
    int maxv = pow10(digits) - 1;
    if (LOAD_ON && ld) return validBcd(lv, digits) ? fromBcd(lv, digits) : v;
    if (!en) return v;
    if (up) return (v == maxv) ? (wrap ? 0 : maxv) : v + 1;
    return (v == 0) ? (wrap ? maxv : 0) : v - 1;
  endfunction

  function automatic logic nextErr(input int digits, input logic ld, input logic [15:0] lv);
    return LOAD_ON && ld && !validBcd(lv, digits);
  endfunction

  function automatic logic tcOf(input int v, input int digits);
    return EN && ((UP && v == pow10(digits) - 1) || (!UP && v == 0));
  endfunction

  always @(posedge CLK_in or posedge RESET) begin
    if (RESET) begin
      m2 = 0; ms = 0; m4 = 0;
      e2 = 1'b0; es = 1'b0; e4 = 1'b0;
    end else begin
      e2 = nextErr(2, LOAD, LOAD_VAL & 16'h00FF);
      es = nextErr(2, LOAD, LOAD_VAL & 16'h00FF);
      e4 = nextErr(4, LOAD, LOAD_VAL);
      m2 = nextCount(m2, 2, 1'b1, EN, UP, LOAD, LOAD_VAL & 16'h00FF);
      ms = nextCount(ms, 2, 1'b0, EN, UP, LOAD, LOAD_VAL & 16'h00FF);
      m4 = nextCount(m4, 4, 1'b1, EN, UP, LOAD, LOAD_VAL);
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK_in) begin
    checkOutput("cnt2", {8'h00, bcd2}, toBcd(m2));
    checkOutput("cnts", {8'h00, bcds}, toBcd(ms));
    checkOutput("cnt4", bcd4, toBcd(m4));
    checkOutput("tc2", {15'd0, tc2}, {15'd0, tcOf(m2, 2)});
    checkOutput("tcs", {15'd0, tcs}, {15'd0, tcOf(ms, 2)});
    checkOutput("tc4", {15'd0, tc4}, {15'd0, tcOf(m4, 4)});
    checkOutput("err2", {15'd0, err2}, {15'd0, e2});
    checkOutput("errs", {15'd0, errs}, {15'd0, es});
    checkOutput("err4", {15'd0, err4}, {15'd0, e4});
  end

  task automatic applyStimulus(input logic en, input logic up, input logic ld,
                               input logic [15:0] lv);
    EN = en; UP = up; LOAD = ld; LOAD_VAL = lv;
    @(posedge CLK_in);
    #2;
  endtask

  initial begin
    RESET = 1'b1; EN = 1'b0; UP = 1'b0; LOAD = 1'b0; LOAD_VAL = '0;
    repeat (2) @(posedge CLK_in);
    #2;
    RESET = 1'b0;
    checkOutput("rst_cnt4", bcd4, 16'h0000);
    checkOutput("rst_err2", {15'd0, err2}, 16'h0000);

    // Down from zero: wrap versions roll to all nines, saturating one holds
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("dn0_cnt2", {8'h00, bcd2}, 16'h0099);
    checkOutput("dn0_cnts", {8'h00, bcds}, 16'h0000);
    checkOutput("dn0_cnt4", bcd4, 16'h9999);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    checkOutput("up9_cnt4", bcd4, 16'h0000);

    for (int i = 0; i < 99; i++) applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    checkOutput("up99_cnt2", {8'h00, bcd2}, 16'h0099);
    checkOutput("up99_tc2", {15'd0, tc2}, 16'h0001);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    checkOutput("up100_cnt2", {8'h00, bcd2}, 16'h0000);
    checkOutput("up100_cnts", {8'h00, bcds}, 16'h0099);
    checkOutput("up100_cnt4", bcd4, 16'h0100);

    // Direction flips every edge while enabled
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'(i % 2), 1'b0, 16'h0000);

    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0005);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
`ifdef BCD_LOAD_EN
    checkOutput("ld5_cnt2", {8'h00, bcd2}, 16'h0098);
    checkOutput("ld5_cnts", {8'h00, bcds}, 16'h0000);
    checkOutput("ld5_cnt4", bcd4, 16'h9998);
`endif

    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0099);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
`ifdef BCD_LOAD_EN
    checkOutput("sat_cnts", {8'h00, bcds}, 16'h0000);
    checkOutput("sat_cnt2", {8'h00, bcd2}, 16'h0097);
`endif

    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0042);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h001A);
`ifdef BCD_LOAD_EN
    checkOutput("rej_cnt2", {8'h00, bcd2}, 16'h0042);
    checkOutput("rej_err2", {15'd0, err2}, 16'h0001);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("rej_err2_clr", {15'd0, err2}, 16'h0000);

    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0057);
    EN = 1'b1; UP = 1'b1; LOAD = 1'b1; LOAD_VAL = 16'h0033;
    #1;
    RESET = 1'b1;
    #1;
    checkOutput("arst_cnt2", {8'h00, bcd2}, 16'h0000);
    checkOutput("arst_cnt4", bcd4, 16'h0000);
    @(posedge CLK_in);
    #2;
    checkOutput("arst_hold2", {8'h00, bcd2}, 16'h0000);
    RESET = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    checkOutput("arst_first", {8'h00, bcd2}, 16'h0001);

    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0999);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
`ifdef BCD_LOAD_EN
    checkOutput("c4_up", bcd4, 16'h1000);
`endif
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
`ifdef BCD_LOAD_EN
    checkOutput("c4_dn", bcd4, 16'h0999);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
